crono_timer: RTL
================

CRONO_TIMER -- requirements
Module: crono_timer

Interface
REQ-001 SHALL have ports: CLK_Crono  input  1  system clock, all state changes on rising edge.
REQ-002 SHALL have: reset  input  1  asynchronous, active-low reset; 0 forces reset state immediately.
REQ-003 SHALL have: tick_1hz  input  1  one-cycle enable pulse, one per second, synchronous to CLK_Crono.
REQ-004 SHALL have: load  input  1  capture hh_in/mm_in/ss_in as the countdown value.
REQ-005 SHALL have: start  input  1  begin or resume countdown.
REQ-006 SHALL have: stop  input  1  pause countdown.
REQ-007 SHALL have: hh_in, mm_in, ss_in  input  8 each  packed BCD (tens[7:4], units[3:0]) preset value.
REQ-008 SHALL have: hh, mm, ss  output  8 each  current packed BCD remaining time.
REQ-009 SHALL have: running  output  1  high while in RUN.
REQ-010 SHALL have: fin_crono  output  1  level, high in DONE; drives the downstream ring/blink generator.
REQ-011 SHALL have: estado  output  2  state code IDLE=00, PAUSE=01, RUN=10, DONE=11.

Function
REQ-012 SHALL implement FSM IDLE, PAUSE, RUN, DONE; all outputs registered.
REQ-013 SHALL, on load in any state, write preset to hh/mm/ss and enter PAUSE on the same edge; load overrides start, stop and tick_1hz.
REQ-014 SHALL, on start without load in PAUSE, enter RUN next edge if the value is non-zero, else enter DONE.
REQ-015 SHALL, on stop in RUN, enter PAUSE; stop and start together resolve to stop.
REQ-016 SHALL ignore start/stop in IDLE and DONE; ignore tick_1hz outside RUN.
REQ-017 SHALL, on each edge with tick_1hz=1 in RUN, decrement by one second with BCD borrow: ss units 0->9 with tens-1; ss=00 and mm>0 -> ss=59, mm-1; ss=mm=00 and hh>0 -> ss=mm=59, hh-1.
REQ-018 SHALL, on the tick edge that writes 00:00:00, enter DONE on that same edge; fin_crono is high from the next cycle, zero extra latency.
REQ-019 SHALL hold fin_crono high and hh/mm/ss at 00 in DONE until load or reset; a level (not pulse) so a slower downstream clock cannot miss it.
REQ-020 SHALL never decrement below 00:00:00; hh range 00-23, mm/ss range 00-59.
REQ-021 SHALL, on stop coincident with tick_1hz in RUN, apply the decrement and then enter PAUSE.

Reset
REQ-022 SHALL, while reset=0, force estado=IDLE, hh=mm=ss=8'h00, running=0, fin_crono=0, asynchronously.
REQ-023 SHALL, after reset release, remain in IDLE until the first load.
REQ-024 SHALL, on reset asserted mid-count, discard the count; no fin_crono is produced.

Configuration
REQ-025 SHALL support macro CRONO_INPUT_CLAMP_EN.
REQ-026 SHALL, with CRONO_INPUT_CLAMP_EN defined, clamp each loaded field: any BCD digit >9 or hh>23 -> hh=23; mm>59 -> 59; ss>59 -> 59; load then proceeds per REQ-013.
REQ-027 SHALL, without CRONO_INPUT_CLAMP_EN, reject a load containing any out-of-range field: state and hh/mm/ss unchanged.

Verification
REQ-028 SHALL test: reset=0 mid-RUN at 00:00:05 -> immediately estado=00, all outputs 0, fin_crono=0.
REQ-029 SHALL test: load 00:01:00, start, 60 ticks -> sequence 00:00:59...00:00:00, fin_crono=1 one cycle after 60th tick, running=0.
REQ-030 SHALL test: load 01:00:00, start, 1 tick -> 00:59:59; stop+start same cycle -> PAUSE, further ticks no change.
REQ-031 SHALL test: load 00:00:00, start -> DONE next edge, fin_crono=1; load 00:00:10 in DONE -> PAUSE, fin_crono=0.
REQ-032 SHALL test: load 00:75:80 -> with macro 00:59:59; without macro value and state unchanged.
REQ-033 SHALL test: load and tick_1hz same edge in RUN at 00:00:30 with preset 00:00:10 -> 00:00:10, estado=PAUSE.

Source files
------------

// File: rtl/crono_timer.sv
// rtl/crono_timer.sv - BCD hh:mm:ss countdown timer with IDLE/PAUSE/RUN/DONE control FSM
// Optional CRONO_INPUT_CLAMP_EN: clamp out-of-range presets instead of rejecting the load.
module crono_timer (
    input  logic       CLK_Crono,
    input  logic       reset,
    input  logic       tick_1hz,
    input  logic       load,
    input  logic       start,
    input  logic       stop,
    input  logic [7:0] hh_in,
    input  logic [7:0] mm_in,
    input  logic [7:0] ss_in,
    output logic [7:0] hh,
    output logic [7:0] mm,
    output logic [7:0] ss,
    output logic       running,
    output logic       fin_crono,
    output logic [1:0] estado
);

    localparam logic [1:0] IDLE  = 2'b00;
    localparam logic [1:0] PAUSE = 2'b01;
    localparam logic [1:0] RUN   = 2'b10;
    localparam logic [1:0] DONE  = 2'b11;

    // Both digits must be decimal; with valid digits, packed BCD orders like binary.
    function automatic logic bcd_ok(input logic [7:0] v, input logic [7:0] max_v);
        return (v[3:0] <= 4'd9) && (v[7:4] <= 4'd9) && (v <= max_v);
    endfunction

    // One-step BCD decrement; 00 wraps to 59 (callers only wrap ss/mm fields).
    function automatic logic [7:0] bcd_dec(input logic [7:0] v);
        if (v[3:0] != 4'd0)
            return {v[7:4], v[3:0] - 4'd1};
        else if (v[7:4] != 4'd0)
            return {v[7:4] - 4'd1, 4'd9};
        else
            return 8'h59;
    endfunction

    logic [7:0] ld_hh, ld_mm, ld_ss;
    logic       ld_ok;

`ifdef CRONO_INPUT_CLAMP_EN
    always_comb begin
        ld_ok = 1'b1;
        ld_hh = bcd_ok(hh_in, 8'h23) ? hh_in : 8'h23;
        ld_mm = bcd_ok(mm_in, 8'h59) ? mm_in : 8'h59;
        ld_ss = bcd_ok(ss_in, 8'h59) ? ss_in : 8'h59;
    end
`else
    always_comb begin
        ld_ok = bcd_ok(hh_in, 8'h23) && bcd_ok(mm_in, 8'h59) && bcd_ok(ss_in, 8'h59);
        ld_hh = hh_in;
        ld_mm = mm_in;
        ld_ss = ss_in;
    end
`endif

    logic [7:0] dec_hh, dec_mm, dec_ss;
    logic       dec_zero;

    always_comb begin
        dec_hh = hh;
        dec_mm = mm;
        dec_ss = ss;
        if (ss != 8'h00) begin
            dec_ss = bcd_dec(ss);
        end else if (mm != 8'h00) begin
            dec_ss = 8'h59;
            dec_mm = bcd_dec(mm);
        end else if (hh != 8'h00) begin
            dec_ss = 8'h59;
            dec_mm = 8'h59;
            dec_hh = bcd_dec(hh);
        end
        dec_zero = (dec_hh == 8'h00) && (dec_mm == 8'h00) && (dec_ss == 8'h00);
    end

    logic [1:0] n_state;
    logic [7:0] n_hh, n_mm, n_ss;
    logic       val_zero;

    assign val_zero = (hh == 8'h00) && (mm == 8'h00) && (ss == 8'h00);

    always_comb begin
        n_state = estado;
        n_hh    = hh;
        n_mm    = mm;
        n_ss    = ss;
        if (load) begin
            // A rejected load still swallows start/stop/tick for this cycle.
            if (ld_ok) begin
                n_state = PAUSE;
                n_hh    = ld_hh;
                n_mm    = ld_mm;
                n_ss    = ld_ss;
            end
        end else begin
            case (estado)
                PAUSE: begin
                    if (start && !stop)
                        n_state = val_zero ? DONE : RUN;
                end
                RUN: begin
                    if (tick_1hz) begin
                        n_hh = dec_hh;
                        n_mm = dec_mm;
                        n_ss = dec_ss;
                        if (dec_zero)
                            n_state = DONE;
                        else if (stop)
                            n_state = PAUSE;
                    end else if (stop) begin
                        n_state = PAUSE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK_Crono or negedge reset) begin
        if (!reset) begin
            estado    <= IDLE;
            hh        <= 8'h00;
            mm        <= 8'h00;
            ss        <= 8'h00;
            running   <= 1'b0;
            fin_crono <= 1'b0;
        end else begin
            estado    <= n_state;
            hh        <= n_hh;
            mm        <= n_mm;
            ss        <= n_ss;
            running   <= (n_state == RUN);
            fin_crono <= (n_state == DONE);
        end
    end

endmodule
